// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. one buffered MDU result,
// with a forced one-cycle pipeline stall when the buffered result starves.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_rd,
  input  logic [DATA_W-1:0] mdu_wdata,
  output logic              mdu_ready,
  output logic              pipe_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_sel,
  output logic              mdu_drop
);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_buf_rd;
  logic [DATA_W-1:0] r_buf_data;
  logic [2:0]        r_starve_cnt;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_wb_sel;
  logic              r_mdu_drop;

  logic              w_pipe_req;
  logic              w_accept;
  logic [2:0]        w_cnt_nxt;

  // The buffer is full exactly when not IDLE, so readiness is pure state.
  assign mdu_ready  = (r_state == IDLE);
  assign pipe_stall = (r_state == FORCE);
  assign w_pipe_req = pipe_we && (pipe_rd != '0);
  assign w_accept   = mdu_valid && mdu_ready;
  assign w_cnt_nxt  = r_starve_cnt + 3'd1;

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign wb_sel   = r_wb_sel;
  assign mdu_drop = r_mdu_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_buf_rd     <= '0;
      r_buf_data   <= '0;
      r_starve_cnt <= '0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_wb_sel     <= 1'b0;
      r_mdu_drop   <= 1'b0;
    end else begin
      r_rf_we    <= 1'b0;
      r_wb_sel   <= 1'b0;
      r_mdu_drop <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pipe_req) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= pipe_rd;
            r_rf_wdata <= pipe_wdata;
          end
          // rd==0 results are consumed here and never buffered
          if (w_accept && (mdu_rd != '0)) begin
            r_buf_rd     <= mdu_rd;
            r_buf_data   <= mdu_wdata;
            r_starve_cnt <= '0;
            r_state      <= WAIT;
          end
        end
        WAIT: begin
          if (!w_pipe_req) begin
            r_rf_we      <= 1'b1;
            r_rf_waddr   <= r_buf_rd;
            r_rf_wdata   <= r_buf_data;
            r_wb_sel     <= 1'b1;
            r_starve_cnt <= '0;
            r_state      <= IDLE;
          end else begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= pipe_rd;
            r_rf_wdata <= pipe_wdata;
            if (pipe_rd == r_buf_rd) begin
              // younger pipeline write to the same register supersedes the MDU result
              r_mdu_drop   <= 1'b1;
              r_starve_cnt <= '0;
              r_state      <= IDLE;
            end else begin
              r_starve_cnt <= w_cnt_nxt;
              if (w_cnt_nxt == 3'(STARVE_LIMIT)) r_state <= FORCE;
            end
          end
        end
        FORCE: begin
          r_rf_we      <= 1'b1;
          r_rf_waddr   <= r_buf_rd;
          r_rf_wdata   <= r_buf_data;
          r_wb_sel     <= 1'b1;
          r_starve_cnt <= '0;
          r_state      <= IDLE;
        end
        default: begin
          r_starve_cnt <= '0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, MDU path, starvation, collision, x0, mid-op reset.
module tb_wb_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_wdata;
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_rd;
  logic [DATA_W-1:0] mdu_wdata;
  logic              mdu_ready;
  logic              pipe_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              wb_sel;
  logic              mdu_drop;

  int n_cmp = 0;
  int n_err = 0;

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wdata(mdu_wdata),
    .mdu_ready(mdu_ready), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_sel(wb_sel), .mdu_drop(mdu_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge, sample 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    pipe_we = we; pipe_rd = rd; pipe_wdata = d;
  endtask

  task automatic mdu(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    mdu_valid = v; mdu_rd = rd; mdu_wdata = d;
  endtask

  initial begin
    rst_n = 1'b0;
    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      pipe(1'($urandom), 5'($urandom), $urandom);
      mdu(1'($urandom), 5'($urandom), $urandom);
      step();
    end
    chk("rst_rf_we", rf_we, 0);
    chk("rst_wb_sel", wb_sel, 0);
    chk("rst_stall", pipe_stall, 0);
    chk("rst_ready", mdu_ready, 1);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_drop", mdu_drop, 0);
    pipe(0, 0, 0); mdu(0, 0, 0);
    rst_n = 1'b1;
    step();

    // first pipeline write
    pipe(1, 3, 32'hA5A5A5A5);
    step();
    chk("p_we", rf_we, 1);
    chk("p_waddr", rf_waddr, 3);
    chk("p_wdata", rf_wdata, 32'hA5A5A5A5);
    chk("p_sel", wb_sel, 0);

    // idle MDU path
    pipe(0, 0, 0);
    mdu(1, 7, 32'h12345678);
    chk("m_ready0", mdu_ready, 1);
    step();
    mdu(0, 0, 0);
    chk("m_ready1", mdu_ready, 0);
    chk("m_we1", rf_we, 0);
    step();
    chk("m_we2", rf_we, 1);
    chk("m_waddr2", rf_waddr, 7);
    chk("m_wdata2", rf_wdata, 32'h12345678);
    chk("m_sel2", wb_sel, 1);
    chk("m_ready2", mdu_ready, 1);
    step();
    chk("m_ready3", mdu_ready, 1);
    chk("m_we3", rf_we, 0);
    chk("m_sel3", wb_sel, 0);
    chk("m_waddr_hold", rf_waddr, 7);

    // starvation: buffered rd=9 loses to rd=2 four times
    mdu(1, 9, 32'h99);
    step();
    mdu(0, 0, 0);
    pipe(1, 2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s_we", rf_we, 1);
      chk("s_waddr", rf_waddr, 2);
      chk("s_sel", wb_sel, 0);
      chk("s_stall", pipe_stall, (i == 3) ? 1 : 0);
    end
    step();
    chk("s_f_stall", pipe_stall, 0);
    chk("s_f_we", rf_we, 1);
    chk("s_f_waddr", rf_waddr, 9);
    chk("s_f_wdata", rf_wdata, 32'h99);
    chk("s_f_sel", wb_sel, 1);
    step();
    chk("s_r_waddr", rf_waddr, 2);
    chk("s_r_sel", wb_sel, 0);
    chk("s_r_stall", pipe_stall, 0);

    // same-rd collision
    pipe(0, 0, 0);
    mdu(1, 5, 32'h1);
    step();
    mdu(0, 0, 0);
    pipe(1, 5, 32'h2);
    step();
    chk("c_we", rf_we, 1);
    chk("c_waddr", rf_waddr, 5);
    chk("c_wdata", rf_wdata, 32'h2);
    chk("c_drop", mdu_drop, 1);
    chk("c_sel", wb_sel, 0);
    pipe(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("c_after_we", rf_we, 0);
      chk("c_after_drop", mdu_drop, 0);
      chk("c_after_ready", mdu_ready, 1);
    end

    // x0 handling
    pipe(1, 0, 32'hDEAD);
    mdu(1, 0, 32'hBEEF);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("x0_we", rf_we, 0);
      chk("x0_ready", mdu_ready, 1);
      chk("x0_stall", pipe_stall, 0);
    end

    // mid-operation reset while rd=11 is buffered
    pipe(1, 4, 32'h44);
    mdu(1, 11, 32'hBB);
    step();
    mdu(0, 0, 0);
    chk("r_ready_wait", mdu_ready, 0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_we", rf_we, 0);
    chk("r_async_ready", mdu_ready, 1);
    step();
    pipe(0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r_no_write", rf_we, 0);
      chk("r_ready", mdu_ready, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
